// File: rtl/div_pkg.sv
// Shared types and helpers for the restoring divider.
// State encoding and counter sizing live here.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

  localparam int DEF_WIDTH = 8;

  function automatic int CNT_W(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_left_register.sv
// Left-shifting register with parallel load.
// Load wins over shift; shift_in enters at the LSB.
module shift_left_register
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic             shift_en,
  input  logic             shift_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;

  // next value: load, else shift, else hold
  always_comb begin
    r_d = r_q;
    if (load_en) begin
      r_d = d;
    end else if (shift_en) begin
      r_d = {r_q[WIDTH-2:0], shift_in};
    end
  end

  // storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
// Optional divide-by-zero detection under DIV_ZERO_DET_EN.
module restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_DET_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam int CW = CNT_W(WIDTH);

  div_state_t state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH:0]   a_val;
  logic [WIDTH-1:0] q_val;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   t_val;
  logic             t_neg;

  logic             a_load, a_shift;
  logic [WIDTH:0]   a_din;
  logic             q_load, q_shift;
  logic             dz_hit;
  logic             unused_a_msb;

  // partial remainder A, one bit wider than the operands
  shift_left_register #(.WIDTH(WIDTH + 1)) u_a (
    .clk      (clk),
    .rst      (rst),
    .load_en  (a_load),
    .shift_en (a_shift),
    .shift_in (q_val[WIDTH-1]),
    .d        (a_din),
    .q        (a_val)
  );

  // Q starts as the dividend and fills with quotient bits
  shift_left_register #(.WIDTH(WIDTH)) u_q (
    .clk      (clk),
    .rst      (rst),
    .load_en  (q_load),
    .shift_en (q_shift),
    .shift_in (~t_neg),
    .d        (dividend),
    .q        (q_val)
  );

  assign a_sh  = {a_val[WIDTH-1:0], q_val[WIDTH-1]};
  assign t_val = a_sh - {1'b0, m_q};
  assign t_neg = t_val[WIDTH];

  // A never exceeds WIDTH bits between steps
  assign unused_a_msb = a_val[WIDTH];

`ifdef DIV_ZERO_DET_EN
  logic dz_q;
  logic dzo_q;

  // remember a zero divisor at accept; flag it with done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dz_q  <= 1'b0;
      dzo_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      dz_q  <= (divisor == '0);
      dzo_q <= 1'b0;
    end else if (state_q == RUN && dz_q) begin
      dzo_q <= 1'b1;
    end
  end

  assign dz_hit      = dz_q;
  assign div_by_zero = dzo_q;
`else
  assign dz_hit = 1'b0;
`endif

  // next state, iteration control and result capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    a_load  = 1'b0;
    a_shift = 1'b0;
    a_din   = '0;
    q_load  = 1'b0;
    q_shift = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = CW'(WIDTH);
          m_d     = divisor;
          a_load  = 1'b1;
          q_load  = 1'b1;
        end
      end
      RUN: begin
        if (dz_hit) begin
          state_d = DONE;
          quo_d   = '1;
          rem_d   = q_val;
        end else if (cnt_q == '0) begin
          state_d = DONE;
          quo_d   = q_val;
          rem_d   = a_val[WIDTH-1:0];
        end else begin
          cnt_d   = cnt_q - CW'(1);
          q_shift = 1'b1;
          if (t_neg) begin
            a_shift = 1'b1;
          end else begin
            a_load = 1'b1;
            a_din  = t_val;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // control and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider (WIDTH=8).
// Covers both builds of DIV_ZERO_DET_EN.
module tb_restoring_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
`ifdef DIV_ZERO_DET_EN
  logic       div_by_zero;
`endif

  int checks = 0;
  int errors = 0;

  restoring_divider #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIV_ZERO_DET_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits at negedges until done (bounded). start drops at drop_at;
  // at pulse_at a stray start with other operands is applied.
  task automatic wait_done(input int drop_at, input int pulse_at,
                           output int n, output bit bz,
                           output bit stable);
    logic [7:0] q0;
    logic [7:0] r0;
    q0 = quotient;
    r0 = remainder;
    n = 0;
    bz = 1'b1;
    stable = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (n == drop_at) start = 1'b0;
      if (n == pulse_at) begin
        start = 1'b1;
        dividend = 8'd9;
        divisor = 8'd3;
      end
      if (n == pulse_at + 1) start = 1'b0;
      bz = bz & busy;
      if (!done && (quotient !== q0 || remainder !== r0))
        stable = 1'b0;
    end while (!done && n < 40);
  endtask

  int  n;
  bit  bz;
  bit  st;
  bit  seen;
  int  dd;
  int  dv;
  int  eq;
  int  er;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quo", quotient, 0);
    chk("rst_rem", remainder, 0);
`ifdef DIV_ZERO_DET_EN
    chk("rst_dz", div_by_zero, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // 100 / 7
    dividend = 8'd100;
    divisor = 8'd7;
    start = 1'b1;
    wait_done(1, -5, n, bz, st);
    chk("a_lat", n, 10);
    chk("a_busy", bz, 1);
    chk("a_stable", st, 1);
    chk("a_quo", quotient, 14);
    chk("a_rem", remainder, 2);
    @(negedge clk);
    chk("a_done_pulse", done, 0);
    chk("a_idle_busy", busy, 0);
    chk("a_hold_quo", quotient, 14);

    // back-to-back with start held high: 255/1 then 5/9
    dividend = 8'd255;
    divisor = 8'd1;
    start = 1'b1;
    wait_done(0, -5, n, bz, st);
    chk("b1_lat", n, 10);
    chk("b1_quo", quotient, 255);
    chk("b1_rem", remainder, 0);
    dividend = 8'd5;
    divisor = 8'd9;
    wait_done(2, -5, n, bz, st);
    chk("b2_lat", n, 11);
    chk("b2_quo", quotient, 0);
    chk("b2_rem", remainder, 5);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b2_no_rerun", busy, 0);

    // stray start during RUN is ignored
    dividend = 8'd200;
    divisor = 8'd13;
    start = 1'b1;
    wait_done(1, 3, n, bz, st);
    chk("c_lat", n, 10);
    chk("c_stable", st, 1);
    chk("c_quo", quotient, 15);
    chk("c_rem", remainder, 5);
    @(negedge clk);

    // reset in the 4th RUN cycle aborts
    dividend = 8'd100;
    divisor = 8'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("d_busy", busy, 0);
    chk("d_done", done, 0);
    chk("d_quo", quotient, 0);
    chk("d_rem", remainder, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("d_no_done", seen, 0);
    dividend = 8'd20;
    divisor = 8'd3;
    start = 1'b1;
    wait_done(1, -5, n, bz, st);
    chk("d_lat", n, 10);
    chk("d_quo2", quotient, 6);
    chk("d_rem2", remainder, 2);
    @(negedge clk);

    // 37 / 0
    dividend = 8'd37;
    divisor = 8'd0;
    start = 1'b1;
    wait_done(1, -5, n, bz, st);
`ifdef DIV_ZERO_DET_EN
    chk("z_lat", n, 2);
    chk("z_flag", div_by_zero, 1);
`else
    chk("z_lat", n, 10);
`endif
    chk("z_quo", quotient, 255);
    chk("z_rem", remainder, 37);
    @(negedge clk);
`ifdef DIV_ZERO_DET_EN
    chk("z_flag_held", div_by_zero, 1);
`endif

    // normal division after the zero case
    dividend = 8'd50;
    divisor = 8'd5;
    start = 1'b1;
    wait_done(1, -5, n, bz, st);
    chk("e_lat", n, 10);
    chk("e_quo", quotient, 10);
    chk("e_rem", remainder, 0);
`ifdef DIV_ZERO_DET_EN
    chk("e_flag_clr", div_by_zero, 0);
`endif
    @(negedge clk);

    // sweep against a / and % reference
    for (int i = 0; i < 16; i++) begin
      dd = int'($urandom_range(0, 255));
      dv = (i == 5) ? 0 : int'($urandom_range(0, 255));
      if (i == 9) dv = 1;
      eq = (dv == 0) ? 255 : dd / dv;
      er = (dv == 0) ? dd : dd % dv;
      dividend = 8'(dd);
      divisor = 8'(dv);
      start = 1'b1;
      wait_done(1, -5, n, bz, st);
      chk($sformatf("s%0d_quo", i), quotient, eq);
      chk($sformatf("s%0d_rem", i), remainder, er);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
